// File: rtl/hdlverifier_capture_pkg.sv
// Shared definitions for the multi-channel trigger-capture buffer:
// state encoding, depth and channel-select width helpers.
package hdlverifier_capture_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_FULL  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_PRE   = S_PRE,
    ST_ARMED = S_ARMED,
    ST_POST  = S_POST,
    ST_FULL  = S_FULL
  } state_e;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int ch_w_of(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/hdlverifier_capture_ram.sv
// Simple dual-port sample RAM, one clock, one write and one read port.
// Read data is registered: address in cycle N, data valid in cycle N+1. No stalls.
module hdlverifier_capture_ram
  import hdlverifier_capture_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  wr_vld,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_dat,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_dat
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_dat_q;

  // Contents are deliberately not reset so a capture survives abort and reset.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[wr_addr] <= wr_dat;
    end
    rd_dat_q <= mem[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/hdlverifier_capture_multi.sv
// Multi-channel trigger capture into a circular RAM with pre-trigger window and decimation.
// Readback latency 2 cycles, one request per cycle; no backpressure, reads honoured only in FULL.
module hdlverifier_capture_multi
  import hdlverifier_capture_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_CH     = 4,
  parameter  int ADDR_WIDTH = 5,
  localparam int CH_W       = ch_w_of(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_enable,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data,
  input  logic [NUM_CH-1:0]            trigger,
  input  logic [NUM_CH-1:0]            trigger_mask,
  input  logic                         trigger_and,
  input  logic                         trigger_edge,
  input  logic [ADDR_WIDTH-1:0]        trigger_pos,
  input  logic [7:0]                   decim,
  input  logic                         run,
  input  logic                         immediate,
  output logic                         flag_full,
  output logic                         busy,
  output logic [2:0]                   state,
  input  logic                         rd_req,
  input  logic [CH_W-1:0]              rd_ch,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic                         rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  state_e                  state_q, state_d;
  logic                    run_d1_q, run_d1_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   tp_q, tp_d;
  logic [7:0]              dcnt_q, dcnt_d;
  logic [7:0]              decim_q, decim_d;
  logic                    and_q, and_d;
  logic                    edge_q, edge_d;
  logic                    prev_q, prev_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [CH_W-1:0]         rd_ch_q, rd_ch_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic                    capturing;
  logic                    accept;
  logic                    run_rise;
  logic                    cond;
  logic                    hit;
  logic [ADDR_WIDTH:0]     cnt_inc;
  logic [ADDR_WIDTH-1:0]   ram_rd_addr;
  logic [NUM_CH*DATA_WIDTH-1:0] ram_rd_dat;

  // Trigger combiner; an all-zero mask never fires, even in AND mode.
  always_comb begin
    cond = 1'b0;
    if (mask_q != '0) begin
      cond = and_q ? (&(trigger | ~mask_q)) : (|(trigger & mask_q));
    end
    hit = immediate | (edge_q ? (cond & ~prev_q) : cond);
  end

  always_comb begin
    state_d   = state_q;
    run_d1_d  = run;
    waddr_d   = waddr_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    tp_d      = tp_q;
    dcnt_d    = dcnt_q;
    decim_d   = decim_q;
    and_d     = and_q;
    edge_d    = edge_q;
    prev_d    = prev_q;
    mask_d    = mask_q;
    run_rise  = run & ~run_d1_q;
    capturing = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
    accept    = capturing && clk_enable && (dcnt_q == '0);
    cnt_inc   = {1'b0, cnt_q} + (ADDR_WIDTH+1)'(1);

    if (capturing && clk_enable) begin
      dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 8'd1;
    end
    if (accept) begin
      waddr_d = waddr_q + ADDR_WIDTH'(1);
      prev_d  = cond;
    end

    case (state_q)
      ST_IDLE: begin
        waddr_d = '0;
        cnt_d   = '0;
        dcnt_d  = '0;
        prev_d  = 1'b0;
        if (run_rise) begin
          tp_d    = trigger_pos;
          decim_d = decim;
          and_d   = trigger_and;
          edge_d  = trigger_edge;
          mask_d  = trigger_mask;
          state_d = (trigger_pos == '0) ? ST_ARMED : ST_PRE;
        end
      end
      ST_PRE: begin
        if (accept) begin
          if (cnt_inc == {1'b0, tp_q}) begin
            cnt_d   = '0;
            state_d = ST_ARMED;
          end else begin
            cnt_d = cnt_inc[ADDR_WIDTH-1:0];
          end
        end
      end
      ST_ARMED: begin
        if (accept && hit) begin
          cnt_d   = '0;
          state_d = (tp_q == '1) ? ST_FULL : ST_POST;
        end
      end
      ST_POST: begin
        // ~tp_q is DEPTH-1-trigger_pos, the post-trigger sample count.
        if (accept) begin
          if (cnt_inc == {1'b0, ~tp_q}) begin
            state_d = ST_FULL;
          end else begin
            cnt_d = cnt_inc[ADDR_WIDTH-1:0];
          end
        end
      end
      ST_FULL: begin
        state_d = ST_FULL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q != ST_IDLE) && !run) begin
      state_d = ST_IDLE;
    end
    // After exactly DEPTH or more writes the next write slot holds the oldest sample.
    if (state_d == ST_FULL) begin
      base_d = waddr_d;
    end
  end

  always_comb begin
    ram_rd_addr = base_q + rd_addr;
    rd_pend_d   = rd_req && (state_q == ST_FULL);
    rd_ch_d     = rd_ch;
    rd_valid_d  = rd_pend_q;
    rd_data_d   = rd_data_q;
    if (rd_pend_q) begin
      rd_data_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_ch_q == CH_W'(c)) begin
          rd_data_d = ram_rd_dat[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      run_d1_q   <= 1'b0;
      waddr_q    <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      tp_q       <= '0;
      dcnt_q     <= '0;
      decim_q    <= '0;
      and_q      <= 1'b0;
      edge_q     <= 1'b0;
      prev_q     <= 1'b0;
      mask_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_ch_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_d1_q   <= run_d1_d;
      waddr_q    <= waddr_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      tp_q       <= tp_d;
      dcnt_q     <= dcnt_d;
      decim_q    <= decim_d;
      and_q      <= and_d;
      edge_q     <= edge_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      rd_pend_q  <= rd_pend_d;
      rd_ch_q    <= rd_ch_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  hdlverifier_capture_ram #(
    .WIDTH      (NUM_CH*DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_vld  (accept),
    .wr_addr (waddr_q),
    .wr_dat  (data),
    .rd_addr (ram_rd_addr),
    .rd_dat  (ram_rd_dat)
  );

  assign flag_full = (state_q == ST_FULL);
  assign busy      = capturing;
  assign state     = state_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_hdlverifier_capture_multi.sv
// Bench for hdlverifier_capture_multi: table-driven captures plus random captures
// scored against a sample-list model, and hand-written abort/reset/pipelining sequences.
module tb_hdlverifier_capture_multi;
  import hdlverifier_capture_pkg::*;

  localparam int DW = 8, NCH = 4, AW = 5, DEPTH = 32, CHW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, clk_enable, trigger_and, trigger_edge, run, immediate, rd_req;
  logic [NCH*DW-1:0] data;
  logic [NCH-1:0] trigger, trigger_mask;
  logic [AW-1:0]  trigger_pos, rd_addr;
  logic [7:0]     decim;
  logic [CHW-1:0] rd_ch;
  logic           flag_full, busy, rd_valid;
  logic [2:0]     state;
  logic [DW-1:0]  rd_data;
  logic           x_full, x_busy, x_valid;
  logic [2:0]     x_state;
  logic [DW-1:0]  x_data;

  hdlverifier_capture_multi #(.DATA_WIDTH(DW), .NUM_CH(NCH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .data(data), .trigger(trigger),
    .trigger_mask(trigger_mask), .trigger_and(trigger_and), .trigger_edge(trigger_edge),
    .trigger_pos(trigger_pos), .decim(decim), .run(run), .immediate(immediate),
    .flag_full(flag_full), .busy(busy), .state(state), .rd_req(rd_req), .rd_ch(rd_ch),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data));

  // Three-channel instance: channel select 3 is out of range and must read back 0.
  hdlverifier_capture_multi #(.DATA_WIDTH(DW), .NUM_CH(3), .ADDR_WIDTH(AW)) dut3 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .data(data[3*DW-1:0]),
    .trigger(trigger[2:0]), .trigger_mask(trigger_mask[2:0]), .trigger_and(trigger_and),
    .trigger_edge(trigger_edge), .trigger_pos(trigger_pos), .decim(decim), .run(run),
    .immediate(immediate), .flag_full(x_full), .busy(x_busy), .state(x_state),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_valid(x_valid), .rd_data(x_data));

  typedef struct {
    string    name;
    bit       rnd;
    int       tp;
    int       dec;
    logic [3:0] mask;
    bit       t_and;
    bit       t_edge;
    bit       imm;
    bit       en_tog;
    logic [3:0] hold;
    logic [3:0] pulse;
    int       pulse_k;
    bit       pulse_hold;
    int       early_end;
    int       chk_ch;
    int       exp_tp;
    int       exp_first;
  } vec_t;

  vec_t vecs[8];
  int   n_chk = 0;
  int   n_pass = 0;
  int   rq_ch[$];
  int   rq_adr[$];
  int   rq_exp[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Issue queued reads back to back; each response is due two cycles after its request.
  task automatic rd_burst(input string nm);
    int n;
    bit xq[$];
    n = rq_ch.size();
    for (int j = 0; j <= n + 1; j++) begin
      if (j < n) begin
        rd_req  = 1'b1;
        rd_ch   = CHW'(rq_ch[j]);
        rd_addr = AW'(rq_adr[j]);
        xq.push_back(rq_ch[j] == 3 && x_full == 1'b1);
      end else begin
        rd_req = 1'b0;
      end
      tick;
      if (j >= 1 && j <= n) begin
        check($sformatf("%s rd_valid req%0d", nm, j-1), int'(rd_valid), 1);
        check($sformatf("%s rd_data ch%0d idx%0d", nm, rq_ch[j-1], rq_adr[j-1]),
              int'(rd_data), rq_exp[j-1]);
        if (xq[j-1]) begin
          check($sformatf("%s oob_ch valid req%0d", nm, j-1), int'(x_valid), 1);
          check($sformatf("%s oob_ch data req%0d", nm, j-1), int'(x_data), 0);
        end
      end else begin
        check($sformatf("%s rd_valid idle%0d", nm, j), int'(rd_valid), 0);
      end
    end
    rq_ch.delete(); rq_adr.delete(); rq_exp.delete();
  endtask

  task automatic do_capture(input vec_t v);
    int tp, dec, k, last_st, tidx, ecount, base;
    logic [3:0] mask, trg;
    bit ta, te, en, im, cond, hit, prev;
    logic [NCH*DW-1:0] acc[$];
    logic [NCH*DW-1:0] dat_r[$];
    logic [3:0] trg_r[$];
    bit en_r[$];
    bit imm_r[$];
    if (v.rnd) begin
      tp = $urandom_range(DEPTH-1); dec = $urandom_range(3);
      mask = 4'($urandom_range(15, 1)); ta = 1'($urandom); te = 1'($urandom);
    end else begin
      tp = v.tp; dec = v.dec; mask = v.mask; ta = v.t_and; te = v.t_edge;
    end
    trigger_pos = AW'(tp); decim = 8'(dec); trigger_mask = mask;
    trigger_and = ta; trigger_edge = te;
    immediate = 1'b0; clk_enable = 1'b0; trigger = '0; run = 1'b0;
    tick;
    run = 1'b1;
    tick;
    check({v.name, " arm_state"}, int'(state), (tp == 0) ? 2 : 1);
    // Config inputs are latched at arm; scramble them for the rest of the capture.
    trigger_pos = AW'(tp + 7); decim = 8'(dec + 5); trigger_mask = ~mask;
    trigger_and = ~ta; trigger_edge = ~te;
    k = 0; last_st = 0;
    while (flag_full !== 1'b1 && k < 3000) begin
      en = v.rnd ? ($urandom_range(3) != 0) : (v.en_tog ? (k % 2 == 0) : 1'b1);
      for (int c = 0; c < NCH; c++) data[c*DW +: DW] = v.rnd ? DW'($urandom) : DW'(c*64 + k);
      if (v.rnd) trg = 4'($urandom);
      else trg = v.hold | (((k < v.early_end) || (k == v.pulse_k) || (v.pulse_hold && k > v.pulse_k))
                           ? v.pulse : 4'b0000);
      im = v.rnd ? ($urandom_range(40) == 0) : v.imm;
      clk_enable = en; trigger = trg; immediate = im;
      en_r.push_back(en); dat_r.push_back(data); trg_r.push_back(trg); imm_r.push_back(im);
      last_st = int'(state);
      tick;
      k++;
    end
    clk_enable = 1'b0; immediate = 1'b0; trigger = '0;
    check({v.name, " flag_full"}, int'(flag_full), 1);
    if (flag_full !== 1'b1) return;
    check({v.name, " busy"}, int'(busy), 0);
    check({v.name, " state_full"}, int'(state), 4);
    check({v.name, " state_before_full"}, last_st, (tp == DEPTH-1) ? 2 : 3);

    // Reference: list of accepted samples, first hit at or after the pre-window.
    ecount = 0; prev = 1'b0; tidx = -1;
    for (int i = 0; i < en_r.size(); i++) begin
      if (en_r[i]) begin
        if (ecount % (dec + 1) == 0) begin
          if (mask == 4'b0000) cond = 1'b0;
          else cond = ta ? ((trg_r[i] & mask) == mask) : ((trg_r[i] & mask) != 4'b0000);
          hit = imm_r[i] || (te ? (cond && !prev) : cond);
          prev = cond;
          if (tidx < 0 && acc.size() >= tp && hit) tidx = acc.size();
          acc.push_back(dat_r[i]);
        end
        ecount++;
      end
    end
    check({v.name, " trigger_found"}, int'(tidx >= 0), 1);
    if (tidx < 0) return;
    check({v.name, " accept_count"}, acc.size(), tidx - tp + DEPTH);
    base = tidx - tp;
    if (!v.rnd) begin
      rq_ch.push_back(v.chk_ch); rq_adr.push_back(tp); rq_exp.push_back(v.exp_tp);
      rq_ch.push_back(v.chk_ch); rq_adr.push_back(0);  rq_exp.push_back(v.exp_first);
    end
    for (int ch = 0; ch < NCH; ch++) begin
      for (int a = 0; a < DEPTH; a++) begin
        rq_ch.push_back(ch); rq_adr.push_back(a);
        rq_exp.push_back((base + a < acc.size()) ? int'(acc[base+a][ch*DW +: DW]) : -1);
      end
    end
    rd_burst(v.name);
  endtask

  task automatic release_run(input string nm);
    run = 1'b0;
    tick;
    check({nm, " release_state"}, int'(state), 0);
    check({nm, " release_flag"}, int'(flag_full), 0);
  endtask

  initial begin
    //          name     rnd  tp dec mask     and   edge  imm   tog   hold     pulse    pk pho   ee ch  exp_tp first
    vecs[0] = '{"basic",  1'b0, 10, 0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 50, 1'b0, 0,  1, 114, 104};
    vecs[1] = '{"and_edge",1'b0,10, 0, 4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0100, 40, 1'b1, 12, 2, 168, 158};
    vecs[2] = '{"decim",  1'b0, 0,  2, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, -1, 1'b0, 0,  3, 192, 192};
    vecs[3] = '{"tp31",   1'b0, 31, 0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, -1, 1'b0, 0,  0, 31,  0};
    vecs[4] = '{"tp0",    1'b0, 0,  0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 5,  1'b0, 0,  3, 197, 197};
    vecs[5] = '{"rand0",  1'b1, 0,  0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, -1, 1'b0, 0,  0, 0,   0};
    vecs[6] = '{"rand1",  1'b1, 0,  0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, -1, 1'b0, 0,  0, 0,   0};
    vecs[7] = '{"rand2",  1'b1, 0,  0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, -1, 1'b0, 0,  0, 0,   0};

    reset = 1'b1; clk_enable = 1'b0; data = '0; trigger = '0; trigger_mask = '0;
    trigger_and = 1'b0; trigger_edge = 1'b0; trigger_pos = '0; decim = '0; run = 1'b0;
    immediate = 1'b0; rd_req = 1'b0; rd_ch = '0; rd_addr = '0;
    tick; tick;
    reset = 1'b0;
    tick;
    check("reset state", int'(state), 0);
    check("reset flag_full", int'(flag_full), 0);
    check("reset busy", int'(busy), 0);
    check("reset rd_valid", int'(rd_valid), 0);
    check("reset rd_data", int'(rd_data), 0);

    // Run high for a single cycle: arm, then abort.
    trigger_pos = 10; run = 1'b1;
    tick;
    check("pulse_run armed", int'(state), 1);
    check("pulse_run busy", int'(busy), 1);
    run = 1'b0;
    tick;
    check("pulse_run idle", int'(state), 0);

    for (int i = 0; i < 8; i++) begin
      do_capture(vecs[i]);
      if (i == 0) begin
        // A request in flight when run drops is still delivered, then rd_data holds.
        rd_req = 1'b1; rd_ch = 2'd1; rd_addr = 5'd10;
        tick;
        rd_req = 1'b0; run = 1'b0;
        tick;
        check("inflight state", int'(state), 0);
        check("inflight rd_valid", int'(rd_valid), 1);
        check("inflight rd_data", int'(rd_data), 114);
        tick;
        check("inflight pulse_end", int'(rd_valid), 0);
        check("inflight hold", int'(rd_data), 114);
        check("inflight flag", int'(flag_full), 0);
      end else begin
        release_run(vecs[i].name);
      end
    end

    // Abort in POST.
    trigger_pos = 10; decim = 0; trigger_mask = 4'b0010; trigger_and = 1'b0;
    trigger_edge = 1'b0; immediate = 1'b0; run = 1'b0;
    tick;
    run = 1'b1;
    tick;
    for (int k = 0; k < 100 && state != 3'd3; k++) begin
      clk_enable = 1'b1;
      trigger = (k == 20) ? 4'b0010 : 4'b0000;
      tick;
    end
    check("abort reach_post", int'(state), 3);
    trigger = '0;
    tick; tick;
    run = 1'b0;
    tick;
    check("abort state", int'(state), 0);
    check("abort flag_full", int'(flag_full), 0);
    check("abort busy", int'(busy), 0);
    clk_enable = 1'b0; rd_req = 1'b1; rd_ch = 2'd0; rd_addr = 5'd0;
    tick;
    check("abort rd_ignored0", int'(rd_valid), 0);
    tick;
    check("abort rd_ignored1", int'(rd_valid), 0);
    rd_req = 1'b0;
    tick;
    check("abort rd_ignored2", int'(rd_valid), 0);
    do_capture(vecs[0]);
    release_run("rearm_after_abort");

    // Reset while ARMED.
    trigger_pos = 0; trigger_mask = 4'b0000; immediate = 1'b0; run = 1'b0;
    tick;
    run = 1'b1;
    tick;
    check("reset_armed armed", int'(state), 2);
    clk_enable = 1'b1;
    tick; tick;
    reset = 1'b1; run = 1'b0;
    tick;
    check("reset_armed state", int'(state), 0);
    check("reset_armed busy", int'(busy), 0);
    check("reset_armed flag", int'(flag_full), 0);
    reset = 1'b0; clk_enable = 1'b0;
    tick;
    check("reset_armed stays_idle", int'(state), 0);
    do_capture(vecs[3]);
    release_run("rearm_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
